// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequencer placed upstream of counter_8b_full. It steers the counter's
// data/load/down_up/hold_n inputs so that q sweeps lo->hi->lo a programmed
// number of times (or until stopped), optionally dwelling DWELL cycles at each
// bound. The counter's q is fed back on cnt_q so that turnarounds land exactly
// on the bounds and any loss of synchronisation is flagged.
//
// Ports
//   clock_n    : system clock shared with the counter (rising edge active)
//   reset_n    : asynchronous active-low reset
//   start      : level-sampled run request, honoured only when idle
//   stop       : synchronous abort of a run
//   lo, hi     : sweep bounds, latched at start (hi must be >= lo+2)
//   n_sweeps   : sweep count, latched at start; 0 runs until stopped
//   cnt_q      : counter value fed back from counter_8b_full.q
//   data       : counter preload value (latched lo)
//   load       : counter load strobe
//   down_up    : counter direction, 1 = down
//   hold_n     : counter enable, 0 = freeze
//   busy       : high whenever a run is in progress
//   done       : one-cycle pulse when the programmed sweeps complete
//   sweep_cnt  : sweeps completed in the current run
//   err        : sticky flag for bad bounds or desync
module counter_sweep_ctrl #(
    parameter int DWELL = 0
) (
    input  logic       clock_n,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic [7:0] n_sweeps,
    input  logic [7:0] cnt_q,
    output logic [7:0] data,
    output logic       load,
    output logic       down_up,
    output logic       hold_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] sweep_cnt,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_UP       = 3'd2,
        ST_DWELL_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_DWELL_LO = 3'd5
    } state_t;

    localparam logic       DWELL_EN   = (DWELL > 0);
    localparam logic [3:0] DWELL_LAST = (DWELL > 0) ? 4'(DWELL - 1) : 4'd0;

    state_t     state_r, state_s;
    logic [7:0] lo_r, lo_s;
    logic [7:0] hi_r, hi_s;
    logic [7:0] n_r, n_s;
    logic [7:0] sweep_r, sweep_s;
    logic       err_r, err_s;
    logic       done_r, done_s;
    logic [3:0] dwell_r, dwell_s;

    logic       bounds_ok_s;
    logic       out_of_range_s;
    logic [7:0] sweep_inc_s;

    // Bound check is done in 9 bits so lo near 255 cannot wrap into a false pass
    assign bounds_ok_s    = ({1'b0, hi} >= ({1'b0, lo} + 9'd2));
    assign out_of_range_s = (cnt_q < lo_r) || (cnt_q > hi_r);
    assign sweep_inc_s    = sweep_r + 8'd1;

    // Next-state and next-register computation
    always_comb begin
        state_s = state_r;
        lo_s    = lo_r;
        hi_s    = hi_r;
        n_s     = n_r;
        sweep_s = sweep_r;
        err_s   = err_r;
        done_s  = 1'b0;
        dwell_s = dwell_r;

        if (stop && (state_r != ST_IDLE)) begin
            // Abort wins over any turnaround or completion on the same edge
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && bounds_ok_s) begin
                        lo_s    = lo;
                        hi_s    = hi;
                        n_s     = n_sweeps;
                        sweep_s = 8'd0;
                        err_s   = 1'b0;
                        state_s = ST_LOAD;
                    end else if (start) begin
                        err_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_s = ST_UP;
                end
                ST_UP: begin
                    if (out_of_range_s) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (cnt_q == (hi_r - 8'd1)) begin
                        // Counter reaches hi on this same edge
                        dwell_s = 4'd0;
                        state_s = DWELL_EN ? ST_DWELL_HI : ST_DOWN;
                    end else begin
                        state_s = ST_UP;
                    end
                end
                ST_DWELL_HI: begin
                    if (dwell_r == DWELL_LAST) begin
                        state_s = ST_DOWN;
                    end else begin
                        dwell_s = dwell_r + 4'd1;
                    end
                end
                ST_DOWN: begin
                    if (out_of_range_s) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (cnt_q == (lo_r + 8'd1)) begin
                        // Counter reaches lo on this same edge: one sweep done
                        sweep_s = sweep_inc_s;
                        dwell_s = 4'd0;
                        if ((n_r != 8'd0) && (sweep_inc_s == n_r)) begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = DWELL_EN ? ST_DWELL_LO : ST_UP;
                        end
                    end else begin
                        state_s = ST_DOWN;
                    end
                end
                ST_DWELL_LO: begin
                    if (dwell_r == DWELL_LAST) begin
                        state_s = ST_UP;
                    end else begin
                        dwell_s = dwell_r + 4'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock_n or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            lo_r    <= 8'd0;
            hi_r    <= 8'd0;
            n_r     <= 8'd0;
            sweep_r <= 8'd0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            dwell_r <= 4'd0;
        end else begin
            state_r <= state_s;
            lo_r    <= lo_s;
            hi_r    <= hi_s;
            n_r     <= n_s;
            sweep_r <= sweep_s;
            err_r   <= err_s;
            done_r  <= done_s;
            dwell_r <= dwell_s;
        end
    end

    // Moore decode of counter controls from the registered state
    always_comb begin
        load    = 1'b0;
        down_up = 1'b0;
        hold_n  = 1'b0;
        case (state_r)
            ST_IDLE:     begin load = 1'b0; down_up = 1'b0; hold_n = 1'b0; end
            ST_LOAD:     begin load = 1'b1; down_up = 1'b0; hold_n = 1'b1; end
            ST_UP:       begin load = 1'b0; down_up = 1'b0; hold_n = 1'b1; end
            ST_DWELL_HI: begin load = 1'b0; down_up = 1'b1; hold_n = 1'b0; end
            ST_DOWN:     begin load = 1'b0; down_up = 1'b1; hold_n = 1'b1; end
            ST_DWELL_LO: begin load = 1'b0; down_up = 1'b0; hold_n = 1'b0; end
            default:     begin load = 1'b0; down_up = 1'b0; hold_n = 1'b0; end
        endcase
    end

    assign data      = lo_r;
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign sweep_cnt = sweep_r;
    assign err       = err_r;

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Upstream sequencer for `counter_8b_full`. It drives the counter's `data`, `load`, `down_up` and `hold_n` inputs so that `q` performs a programmed triangle sweep: lo→hi→lo, repeated N times or indefinitely, with an optional dwell at each bound. It watches the counter's `q` to turn around exactly at the bounds, and flags loss of synchronisation.

## Interface
Parameters:
- `DWELL`, default 0: cycles `q` is held at each bound before reversing (0–15).

Ports:
- `clock_n` in 1: system clock, shared with `counter_8b_full`; all registers update on its active edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled; begins a run when the block is idle.
- `stop` in 1: synchronous abort.
- `lo` in 8: lower bound, latched at start.
- `hi` in 8: upper bound, latched at start.
- `n_sweeps` in 8: sweep count, latched at start; 0 = run until stopped.
- `cnt_q` in 8: counter value fed back from `counter_8b_full.q`.
- `data` out 8: to counter `data`; equals latched `lo`.
- `load` out 1: to counter `load`.
- `down_up` out 1: to counter `down_up`; 1 = count down, 0 = count up.
- `hold_n` out 1: to counter `hold_n`; 0 = freeze the counter.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the programmed sweeps complete.
- `sweep_cnt` out 8: number of completed sweeps in the current run.
- `err` out 1: sticky; set on bad bounds or on desync.

## Operation
- Outputs are a Moore decode of the registered state. `done`, `sweep_cnt` and `err` are registers.
- States and their outputs (`load` / `down_up` / `hold_n`):
  - IDLE: 0/0/0
  - LOAD: 1/0/1
  - UP: 0/0/1
  - DWELL_HI: 0/1/0
  - DOWN: 0/1/1
  - DWELL_LO: 0/0/0
- IDLE:
  - If `start` and `hi` ≥ `lo`+2: latch `lo`, `hi`, `n_sweeps`; clear `sweep_cnt` and `err`; go to LOAD.
  - If `start` with `hi` < `lo`+2: set `err`, stay in IDLE.
  - `start` in any other state is ignored.
- LOAD: the counter takes `lo` on this edge. Go to UP.
- UP: the turnaround is anticipated. When `cnt_q` == `hi`−1, the counter reaches `hi` on the same edge; go to DWELL_HI if `DWELL`>0, else DOWN.
- DWELL_HI: counts `DWELL` edges, then goes to DOWN.
- DOWN: when `cnt_q` == `lo`+1, the counter reaches `lo` on the same edge and `sweep_cnt` increments.
  - If `n_sweeps`≠0 and the new `sweep_cnt` == `n_sweeps`: go to IDLE and pulse `done`. DWELL_LO is skipped.
  - Otherwise go to DWELL_LO (if `DWELL`>0) or UP.
- DWELL_LO: counts `DWELL` edges, then goes to UP.
- `sweep_cnt` wraps 255→0 in infinite mode. In that mode `done` never asserts.
- Desync: in UP or DOWN, `cnt_q` outside [`lo`,`hi`] sets `err` and forces IDLE. No `done` pulse.
- `stop` has priority over every other transition. Any non-IDLE state goes to IDLE on the next edge. `sweep_cnt` holds and there is no `done` pulse.

## Timing
- Reset values:
  - State IDLE; `data`=0, `load`=0, `down_up`=0, `hold_n`=0.
  - `busy`=0, `done`=0, `sweep_cnt`=0, `err`=0.
- `start` sampled at edge e0 → LOAD after e0; counter `q`=`lo` after e1; first up-count at e2.
- Sweep period is 2·(`hi`−`lo`) + 2·`DWELL` cycles. The final sweep omits DWELL_LO.
- `q` never leaves [`lo`,`hi`]. `hi`=255 and `lo`=0 are legal.
- `done` rises on the same edge that `q` returns to `lo` on the final sweep. `busy` falls on that edge.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). `hold_n`=0 freezes the counter.
- `stop` and the final-sweep turnaround on the same edge: go to IDLE, no `done`. `sweep_cnt` holds its old value.

## Test plan
- `lo`=10, `hi`=13, `DWELL`=0, `n_sweeps`=2 → `q`: 10,11,12,13,12,11,10,11,12,13,12,11,10. `done` pulses once as the final 10 is reached; `sweep_cnt`=2.
- `lo`=0, `hi`=3, `DWELL`=2, `n_sweeps`=1 → `q`: 0,1,2,3,3,3,2,1,0. `hold_n`=0 for the two dwell cycles.
- `lo`=5, `hi`=6 with `start` → `err`=1, `busy` stays 0, `load` never asserts.
- `n_sweeps`=0, `lo`=250, `hi`=255: run 3 sweeps, then assert `stop` while `q`=252 → IDLE next edge, `q` frozen at the value reached on that edge, `sweep_cnt`=3, no `done`.
- Mid-DOWN, force `cnt_q`=200 with `hi`=20 → `err`=1, IDLE, `hold_n`=0.
- Assert `reset_n` low between clock edges mid-UP → all outputs at reset values without waiting for an edge.
